// File: rtl/instr_mem_prog.sv
// Writable instruction memory for the K2 core.
// Serves fetches with one-cycle registered latency, boots with a fixed image,
// and accepts a new program from a host through a valid/ready loader port.
// Fetches are rejected with fetch_err while a load session is in progress.
//
// state | meaning
// ------+---------------------------------------------------------------
// RUN   | serving fetches, waiting for load_start
// LOAD  | accepting host words, load_ready high, fetches rejected as busy
// DONE  | one-cycle load_done pulse, fetches still rejected, back to RUN
module instr_mem_prog #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_data,
    output logic              fetch_err,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] load_base,
    input  logic [ADDR_W:0]   load_len,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    output logic              load_busy,
    output logic              load_done
);

    typedef enum logic [1:0] {RUN, LOAD, DONE} state_t;

    localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_W  = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              wr_en;
    logic              fetch_valid_q, fetch_err_q;
    logic [DATA_W-1:0] fetch_data_q;
    logic              fetch_in_range;

    // Power-on program, zero-extended; everything past word 8 is zero.
    function automatic logic [DATA_W-1:0] boot_word(input int idx);
        case (idx)
            0:       return DATA_W'(8'h08);
            1:       return DATA_W'(8'h19);
            2:       return DATA_W'(8'h20);
            3:       return DATA_W'(8'h10);
            4:       return DATA_W'(8'h70);
            5:       return DATA_W'(8'h00);
            6:       return DATA_W'(8'h14);
            7:       return DATA_W'(8'h04);
            8:       return DATA_W'(8'hB2);
            default: return '0;
        endcase
    endfunction

    // Loader state, pointer, latched length and word counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            ptr_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: latch the session on load_start, count accepted words.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
        case (state_q)
            RUN: begin
                if (load_start) begin
                    len_d   = load_len;
                    cnt_d   = '0;
                    ptr_d   = ADDR_W'(32'(load_base) % DEPTH);
                    state_d = (load_len == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (load_valid) begin
                    wr_en = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    ptr_d = (ptr_q == LAST_W) ? '0 : ptr_q + 1'b1;
                    if (cnt_d == len_q) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Storage: reset reloads the boot image, aborting any partial load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= boot_word(i);
            end
        end else if (wr_en) begin
            mem_q[ptr_q] <= load_data;
        end
    end

    assign fetch_in_range = ({1'b0, fetch_addr} < DEPTH_W);

    // Registered fetch response; data holds when no request is made.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_valid_q <= 1'b0;
            fetch_err_q   <= 1'b0;
            fetch_data_q  <= '0;
        end else begin
            fetch_valid_q <= fetch_req;
            if (fetch_req) begin
                if ((state_q == RUN) && fetch_in_range) begin
                    fetch_err_q  <= 1'b0;
                    fetch_data_q <= mem_q[fetch_addr];
                end else begin
                    fetch_err_q  <= 1'b1;
                    fetch_data_q <= '0;
                end
            end else begin
                fetch_err_q <= 1'b0;
            end
        end
    end

    assign fetch_valid = fetch_valid_q;
    assign fetch_err   = fetch_err_q;
    assign fetch_data  = fetch_data_q;
    assign load_ready  = (state_q == LOAD);
    assign load_busy   = (state_q != RUN);
    assign load_done   = (state_q == DONE);

endmodule

// File: tb/tb_instr_mem_prog.sv
// Bench for instr_mem_prog: a reference memory image predicts every fetch
// response, which is queued when the request is driven and popped one cycle
// later when the response appears. A second instance with DEPTH = 12 covers
// out-of-range addresses.
module tb_instr_mem_prog;

    typedef struct {
        logic       v;
        logic       e;
        logic [7:0] d;
    } rsp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       fetch_req = 1'b0;
    logic [3:0] fetch_addr = '0;
    logic       load_start = 1'b0;
    logic [3:0] load_base = '0;
    logic [4:0] load_len = '0;
    logic       load_valid = 1'b0;
    logic [7:0] load_data = '0;

    logic       fetch_valid, fetch_err, load_ready, load_busy, load_done;
    logic [7:0] fetch_data;
    logic       fv12, fe12, lr12, lb12, ld12;
    logic [7:0] fd12;

    int total = 0;
    int bad   = 0;
    rsp_t exp_q [$];
    rsp_t exp12_q [$];
    logic [7:0] exp_mem [16];
    int wptr;

    instr_mem_prog #(.DATA_W(8), .ADDR_W(4), .DEPTH(16)) u_dut (
        .clk(clk), .reset(reset),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_valid(fetch_valid), .fetch_data(fetch_data), .fetch_err(fetch_err),
        .load_start(load_start), .load_base(load_base), .load_len(load_len),
        .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready), .load_busy(load_busy), .load_done(load_done)
    );

    instr_mem_prog #(.DATA_W(8), .ADDR_W(4), .DEPTH(12)) u_dut12 (
        .clk(clk), .reset(reset),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_valid(fv12), .fetch_data(fd12), .fetch_err(fe12),
        .load_start(load_start), .load_base(load_base), .load_len(load_len),
        .load_valid(load_valid), .load_data(load_data),
        .load_ready(lr12), .load_busy(lb12), .load_done(ld12)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_boot();
        logic [7:0] boot [9] = '{8'h08, 8'h19, 8'h20, 8'h10, 8'h70, 8'h00, 8'h14, 8'h04, 8'hB2};
        for (int i = 0; i < 16; i++) exp_mem[i] = (i < 9) ? boot[i] : 8'h00;
    endtask

    function automatic rsp_t model_rsp(input logic [3:0] a, input logic busy);
        rsp_t r;
        r.v = 1'b1;
        r.e = busy;
        r.d = busy ? 8'h00 : exp_mem[a];
        return r;
    endfunction

    // Record a word the DUT is about to accept in the reference image.
    task automatic model_accept();
        if (load_valid && load_ready) begin
            exp_mem[wptr] = load_data;
            wptr = (wptr + 1) % 16;
        end
    endtask

    task automatic test_reset();
        model_boot();
        step();
        step();
        total++;
        if ({fetch_valid, fetch_err, fetch_data} !== 10'b0) begin
            bad++;
            $display("FAIL reset_fetch got v=%b e=%b d=%h want 0 0 00", fetch_valid, fetch_err, fetch_data);
        end
        total++;
        if ({load_ready, load_busy, load_done} !== 3'b000) begin
            bad++;
            $display("FAIL reset_load got rdy=%b busy=%b done=%b want 000", load_ready, load_busy, load_done);
        end
        reset = 1'b1;
        step();
    endtask

    task automatic test_boot_fetch();
        rsp_t e;
        for (int i = 0; i <= 10; i++) begin
            fetch_req  = 1'b1;
            fetch_addr = (i == 10) ? 4'd8 : 4'(i);
            exp_q.push_back(model_rsp(fetch_addr, 1'b0));
            step();
            e = exp_q.pop_front();
            total++;
            if ({fetch_valid, fetch_err, fetch_data} !== {e.v, e.e, e.d}) begin
                bad++;
                $display("FAIL boot_fetch i=%0d got v=%b e=%b d=%h want v=%b e=%b d=%h",
                         i, fetch_valid, fetch_err, fetch_data, e.v, e.e, e.d);
            end
        end
        fetch_req = 1'b0;
        step();
        total++;
        if ({fetch_valid, fetch_err, fetch_data} !== {1'b0, 1'b0, 8'hB2}) begin
            bad++;
            $display("FAIL idle_hold got v=%b e=%b d=%h want 0 0 b2", fetch_valid, fetch_err, fetch_data);
        end
    endtask

    task automatic test_out_of_range();
        rsp_t e;
        logic [3:0] addrs [4] = '{4'd13, 4'd8, 4'd11, 4'd12};
        for (int i = 0; i < 4; i++) begin
            fetch_req  = 1'b1;
            fetch_addr = addrs[i];
            exp_q.push_back(model_rsp(fetch_addr, 1'b0));
            e.v = 1'b1;
            e.e = (addrs[i] >= 4'd12);
            e.d = e.e ? 8'h00 : exp_mem[addrs[i]];
            exp12_q.push_back(e);
            step();
            e = exp12_q.pop_front();
            total++;
            if ({fv12, fe12, fd12} !== {e.v, e.e, e.d}) begin
                bad++;
                $display("FAIL range12 a=%0d got v=%b e=%b d=%h want v=%b e=%b d=%h",
                         addrs[i], fv12, fe12, fd12, e.v, e.e, e.d);
            end
            e = exp_q.pop_front();
            total++;
            if ({fetch_valid, fetch_err, fetch_data} !== {e.v, e.e, e.d}) begin
                bad++;
                $display("FAIL range16 a=%0d got v=%b e=%b d=%h want v=%b e=%b d=%h",
                         addrs[i], fetch_valid, fetch_err, fetch_data, e.v, e.e, e.d);
            end
        end
        fetch_req = 1'b0;
        step();
    endtask

    task automatic test_load_basic();
        rsp_t e;
        logic [7:0] words [2] = '{8'hAA, 8'hBB};
        logic [3:0] rd [3] = '{4'd3, 4'd4, 4'd5};
        load_start = 1'b1;
        load_base  = 4'd3;
        load_len   = 5'd2;
        load_valid = 1'b1;
        load_data  = words[0];
        wptr = 3;
        step();
        load_start = 1'b0;
        total++;
        if ({load_ready, load_busy, load_done} !== 3'b110) begin
            bad++;
            $display("FAIL load_enter got rdy=%b busy=%b done=%b want 110", load_ready, load_busy, load_done);
        end
        for (int i = 0; i < 2; i++) begin
            load_data  = words[i];
            fetch_req  = 1'b1;
            fetch_addr = 4'd3;
            exp_q.push_back(model_rsp(4'd3, 1'b1));
            model_accept();
            step();
            e = exp_q.pop_front();
            total++;
            if ({fetch_valid, fetch_err, fetch_data} !== {e.v, e.e, e.d}) begin
                bad++;
                $display("FAIL busy_fetch i=%0d got v=%b e=%b d=%h want v=%b e=%b d=%h",
                         i, fetch_valid, fetch_err, fetch_data, e.v, e.e, e.d);
            end
        end
        total++;
        if ({load_ready, load_busy, load_done} !== 3'b011) begin
            bad++;
            $display("FAIL load_done_pulse got rdy=%b busy=%b done=%b want 011", load_ready, load_busy, load_done);
        end
        load_valid = 1'b0;
        exp_q.push_back(model_rsp(4'd3, 1'b1));
        step();
        e = exp_q.pop_front();
        total++;
        if ({fetch_valid, fetch_err, fetch_data, load_busy, load_done} !== {e.v, e.e, e.d, 2'b00}) begin
            bad++;
            $display("FAIL done_fetch got v=%b e=%b d=%h busy=%b done=%b want v=%b e=%b d=%h busy=0 done=0",
                     fetch_valid, fetch_err, fetch_data, load_busy, load_done, e.v, e.e, e.d);
        end
        for (int i = 0; i < 3; i++) begin
            fetch_addr = rd[i];
            exp_q.push_back(model_rsp(rd[i], 1'b0));
            step();
            e = exp_q.pop_front();
            total++;
            if ({fetch_valid, fetch_err, fetch_data} !== {e.v, e.e, e.d}) begin
                bad++;
                $display("FAIL load_readback a=%0d got v=%b e=%b d=%h want v=%b e=%b d=%h",
                         rd[i], fetch_valid, fetch_err, fetch_data, e.v, e.e, e.d);
            end
        end
        fetch_req = 1'b0;
        step();
    endtask

    task automatic test_wrap_gapped();
        rsp_t e;
        logic       pat [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [7:0] dat [5] = '{8'h11, 8'hEE, 8'h22, 8'hEE, 8'h33};
        logic [3:0] rd [3]  = '{4'd15, 4'd0, 4'd1};
        logic [7:0] want [3] = '{8'h11, 8'h22, 8'h33};
        load_start = 1'b1;
        load_base  = 4'd15;
        load_len   = 5'd3;
        wptr = 15;
        step();
        load_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (load_done !== 1'b0) begin
                bad++;
                $display("FAIL gap_early_done i=%0d got done=%b want 0", i, load_done);
            end
            load_valid = pat[i];
            load_data  = dat[i];
            model_accept();
            step();
        end
        load_valid = 1'b0;
        total++;
        if (load_done !== 1'b1) begin
            bad++;
            $display("FAIL gap_done got done=%b want 1", load_done);
        end
        step();
        for (int i = 0; i < 3; i++) begin
            fetch_req  = 1'b1;
            fetch_addr = rd[i];
            exp_q.push_back(model_rsp(rd[i], 1'b0));
            step();
            e = exp_q.pop_front();
            total++;
            if ({fetch_valid, fetch_err, fetch_data} !== {e.v, e.e, e.d} || fetch_data !== want[i]) begin
                bad++;
                $display("FAIL wrap_readback a=%0d got v=%b e=%b d=%h want v=1 e=0 d=%h",
                         rd[i], fetch_valid, fetch_err, fetch_data, want[i]);
            end
        end
        fetch_req = 1'b0;
        step();
    endtask

    task automatic test_len_zero_and_restart();
        rsp_t e;
        int n;
        logic [3:0] rd [4] = '{4'd7, 4'd10, 4'd11, 4'd12};
        load_start = 1'b1;
        load_base  = 4'd7;
        load_len   = 5'd0;
        load_valid = 1'b1;
        load_data  = 8'hEE;
        step();
        load_start = 1'b0;
        total++;
        if ({load_ready, load_busy, load_done} !== 3'b011) begin
            bad++;
            $display("FAIL len0_done got rdy=%b busy=%b done=%b want 011", load_ready, load_busy, load_done);
        end
        step();
        total++;
        if ({load_busy, load_done} !== 2'b00) begin
            bad++;
            $display("FAIL len0_back got busy=%b done=%b want 00", load_busy, load_done);
        end
        load_start = 1'b1;
        load_base  = 4'd10;
        load_len   = 5'd3;
        wptr = 10;
        step();
        load_start = 1'b0;
        n = 0;
        while (load_done !== 1'b1 && n < 10) begin
            load_data = 8'hC0 + 8'(n + 1);
            load_start = (n == 0);
            load_base  = 4'd0;
            load_len   = 5'd1;
            model_accept();
            step();
            n++;
        end
        load_start = 1'b0;
        load_valid = 1'b0;
        total++;
        if (n !== 3 || load_done !== 1'b1) begin
            bad++;
            $display("FAIL restart_len got cycles=%0d done=%b want cycles=3 done=1", n, load_done);
        end
        step();
        for (int i = 0; i < 4; i++) begin
            fetch_req  = 1'b1;
            fetch_addr = rd[i];
            exp_q.push_back(model_rsp(rd[i], 1'b0));
            step();
            e = exp_q.pop_front();
            total++;
            if ({fetch_valid, fetch_err, fetch_data} !== {e.v, e.e, e.d}) begin
                bad++;
                $display("FAIL restart_readback a=%0d got v=%b e=%b d=%h want v=%b e=%b d=%h",
                         rd[i], fetch_valid, fetch_err, fetch_data, e.v, e.e, e.d);
            end
        end
        fetch_req = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_load();
        rsp_t e;
        load_start = 1'b1;
        load_base  = 4'd0;
        load_len   = 5'd5;
        load_valid = 1'b1;
        load_data  = 8'h55;
        step();
        load_start = 1'b0;
        step();
        load_data = 8'h66;
        step();
        load_data = 8'h77;
        reset = 1'b0;
        #2;
        total++;
        if ({load_ready, load_busy, load_done, fetch_valid} !== 4'b0000) begin
            bad++;
            $display("FAIL abort_state got rdy=%b busy=%b done=%b v=%b want 0000",
                     load_ready, load_busy, load_done, fetch_valid);
        end
        step();
        reset = 1'b1;
        load_valid = 1'b0;
        model_boot();
        step();
        for (int i = 0; i < 3; i++) begin
            fetch_req  = 1'b1;
            fetch_addr = 4'(i);
            exp_q.push_back(model_rsp(4'(i), 1'b0));
            step();
            e = exp_q.pop_front();
            total++;
            if ({fetch_valid, fetch_err, fetch_data, load_busy} !== {e.v, e.e, e.d, 1'b0}) begin
                bad++;
                $display("FAIL boot_restore a=%0d got v=%b e=%b d=%h busy=%b want v=%b e=%b d=%h busy=0",
                         i, fetch_valid, fetch_err, fetch_data, load_busy, e.v, e.e, e.d);
            end
        end
        fetch_req = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_boot_fetch();
        test_out_of_range();
        test_load_basic();
        test_wrap_gapped();
        test_len_zero_and_restart();
        test_reset_mid_load();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_mem_prog.md
# instr_mem_prog

Parametrised, writable instruction memory for the K2 core. Serves instruction fetches with one-cycle registered read latency and lets a host stream a new program in through a valid/ready loader port. It boots with a fixed nine-word image, so the core runs without a host. It sits between the program counter/fetch stage and the host/debug loader.

## Interface
Parameters:
- DATA_W, 8, instruction word width in bits
- ADDR_W, 4, fetch/load address width
- DEPTH, 16, number of words; legal range 1..2^ADDR_W

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- fetch_req  in  1  fetch request, sampled each cycle
- fetch_addr  in  ADDR_W  word address of the fetch
- fetch_valid  out  1  response strobe, one cycle after the accepted request
- fetch_data  out  DATA_W  fetched word
- fetch_err  out  1  qualifies fetch_valid: address out of range or memory busy loading
- load_start  in  1  begin a load session (honoured only in RUN)
- load_base  in  ADDR_W  first word address written, sampled with load_start
- load_len  in  ADDR_W+1  number of words to write, sampled with load_start
- load_valid  in  1  host word valid
- load_data  in  DATA_W  host word
- load_ready  out  1  block accepts a word this cycle
- load_busy  out  1  high in LOAD and DONE
- load_done  out  1  one-cycle pulse at session end

## Operation
- Boot image written on reset, zero-extended to DATA_W, at words 0..8: 0x08, 0x19, 0x20, 0x10, 0x70, 0x00, 0x14, 0x04, 0xB2. Words 9..DEPTH-1 = 0.
- FSM states: RUN, LOAD, DONE.
  - RUN -> LOAD on load_start with load_len != 0. Base and length are latched and the write counter is cleared.
  - RUN -> DONE on load_start with load_len == 0. No writes occur.
  - LOAD: load_ready = 1. Each cycle with load_valid & load_ready writes load_data to the write pointer.
    - The write pointer advances by 1 and wraps from DEPTH-1 to 0.
    - If load_base >= DEPTH, the pointer starts at load_base mod DEPTH.
  - LOAD -> DONE in the cycle the write counter reaches the latched length.
  - DONE: load_done = 1 for exactly one cycle, then -> RUN.
  - load_start outside RUN is ignored.
- Fetch:
  - An accepted fetch_req in RUN with fetch_addr < DEPTH gives, next cycle: fetch_valid = 1, fetch_err = 0, fetch_data = mem[fetch_addr].
  - fetch_addr >= DEPTH gives, next cycle: fetch_valid = 1, fetch_err = 1, fetch_data = 0.
  - fetch_req while load_busy gives, next cycle: fetch_valid = 1, fetch_err = 1, fetch_data = 0. The requester retries.
  - No request: fetch_valid = 0, fetch_err = 0, fetch_data holds its last value.
- Read-during-write: a fetch issued in the cycle of the final write (LOAD, same address) is still rejected as busy. Data written in cycle N is readable by fetches issued from the first RUN cycle onward.
- Reset mid-load: the session is aborted and the boot image is fully restored. Partially loaded words are lost.

## Timing
- Reset values:
  - State = RUN.
  - fetch_valid = 0, fetch_data = 0, fetch_err = 0.
  - load_ready = 0, load_busy = 0, load_done = 0.
- Fetch latency: 1 cycle. Back-to-back fetches give a response every cycle.
- Loader throughput: 1 word per cycle. load_ready rises the cycle after load_start is accepted.
- A session of L words with load_valid held high:
  - load_start sampled at cycle 0.
  - Writes occur at cycles 1..L.
  - load_done pulses at cycle L+1.
  - First fetch is accepted at cycle L+2.
- load_ready is 0 in DONE, so no word is accepted there.

## Test plan
- Reset, then fetch addresses 0..8 back-to-back -> responses at T+1: 0x08, 0x19, 0x20, 0x10, 0x70, 0x00, 0x14, 0x04, 0xB2, all with fetch_err = 0. Address 9 -> 0x00.
- load_start with base = 3, len = 2, data 0xAA then 0xBB, valid held high -> load_done pulses 3 cycles after start. Fetch 3 -> 0xAA, fetch 4 -> 0xBB, fetch 5 -> 0x00 (boot image word 5 unchanged).
- DEPTH = 16, base = 15, len = 3, data 0x11/0x22/0x33 with load_valid gapped (1-0-1-0-1) -> mem[15] = 0x11, mem[0] = 0x22, mem[1] = 0x33. load_done comes 1 cycle after the third accepted word.
- fetch_req during LOAD -> fetch_valid = 1, fetch_err = 1, fetch_data = 0. With DEPTH = 12, fetch address 13 in RUN -> fetch_err = 1, fetch_data = 0.
- load_start with len = 0 -> no writes, load_done pulses 1 cycle later. A second load_start asserted during LOAD is ignored, and the session length stays as latched.
- Assert reset after 2 of 5 loader words have been written -> after release, state = RUN, load_busy = 0, and fetch 0 returns 0x08 (boot image restored).
